// File: rtl/mem_spi_bridge.sv
// SPI-slave (mode 0) front-end for a small DFF RAM.
// Two-byte frames: command (rd/wr + address), then data.
`timescale 1ns/1ps
module mem_spi_bridge #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_lr_n,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RD_REQ,
        S_RD_CAP,
        S_DATA,
        S_WR,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_s;
    logic [SYNC_STAGES-1:0] r_cs_s;
    logic [SYNC_STAGES-1:0] r_mosi_s;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_armed;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_miso_sr;
    logic                   r_rd;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_armed;
    logic                   w_in_frame;
    logic [DATA_W-1:0]      w_byte;

    assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
    assign w_cs        = r_cs_s[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_byte      = {r_shift[DATA_W-2:0], w_mosi};
    assign busy        = ~w_cs;

    // After reset, only a cs_n high that really came from the pin
    // (not the reset value of the synchronizer) arms frame start.
    assign w_armed = r_armed | (r_vld[SYNC_STAGES] & r_cs_d);

    assign w_in_frame = (r_state == S_CMD)    ||
                        (r_state == S_RD_REQ) ||
                        (r_state == S_RD_CAP) ||
                        (r_state == S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s <= '0;
            r_cs_s   <= '1;
            r_mosi_s <= '0;
            r_vld    <= '0;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi_sclk};
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
            r_vld    <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs;
            r_armed  <= w_armed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_miso_sr <= '0;
            r_rd      <= 1'b0;
            spi_miso  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ce_n  <= 1'b1;
            mem_lr_n  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            mem_ce_n  <= 1'b1;
            mem_lr_n  <= 1'b1;
            frame_err <= 1'b0;
            if (w_in_frame && w_cs_rise) begin
                r_state   <= S_IDLE;
                spi_miso  <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        spi_miso <= 1'b0;
                        if (w_cs_fall && w_armed) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(DATA_W - 1)) begin
                                mem_addr <= w_byte[ADDR_W-1:0];
                                r_rd     <= w_byte[DATA_W-1];
                                if (w_byte[DATA_W-1]) begin
                                    mem_ce_n <= 1'b0;
                                    r_state  <= S_RD_REQ;
                                end else begin
                                    r_state  <= S_DATA;
                                end
                            end
                        end
                    end
                    S_RD_REQ: r_state <= S_RD_CAP;
                    S_RD_CAP: begin
                        r_miso_sr <= mem_rdata;
                        r_state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (w_sclk_fall && r_rd) begin
                            spi_miso  <= r_miso_sr[DATA_W-1];
                            r_miso_sr <= {r_miso_sr[DATA_W-2:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(2 * DATA_W - 1)) begin
                                spi_miso <= 1'b0;
                                if (r_rd) begin
                                    r_state   <= S_DONE;
                                end else begin
                                    mem_wdata <= w_byte;
                                    mem_lr_n  <= 1'b0;
                                    r_state   <= S_WR;
                                end
                            end
                        end
                    end
                    S_WR: r_state <= S_DONE;
                    S_DONE: begin
                        spi_miso <= 1'b0;
                        if (w_cs) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_spi_bridge.sv
// Bench for mem_spi_bridge: directed frames plus random traffic
// checked against an expected-memory model.
`timescale 1ns/1ps
module tb_mem_spi_bridge;
    localparam int HP = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [3:0] mem_addr;
    logic       mem_ce_n;
    logic       mem_lr_n;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       frame_err;

    logic       ram_clr = 1'b1;
    logic [7:0] ram [16];
    logic [7:0] exp_mem [16];

    int n_chk = 0;
    int n_fail = 0;
    int n_ce = 0, n_lr = 0, n_both = 0, n_err = 0, n_miso = 0;
    logic [3:0] last_raddr = '0, last_waddr = '0;
    logic [7:0] last_wdata = '0;

    always #5 clk = ~clk;

    mem_spi_bridge #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_addr(mem_addr), .mem_ce_n(mem_ce_n),
        .mem_lr_n(mem_lr_n), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy),
        .frame_err(frame_err)
    );

    // Registered-read DFF RAM sitting downstream of the bridge
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (!mem_ce_n) mem_rdata <= ram[mem_addr];
            if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!mem_ce_n) begin
            n_ce <= n_ce + 1;
            last_raddr <= mem_addr;
        end
        if (!mem_lr_n) begin
            n_lr <= n_lr + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (!mem_ce_n && !mem_lr_n) n_both <= n_both + 1;
        if (frame_err) n_err <= n_err + 1;
        if (spi_miso) n_miso <= n_miso + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sclk_edges(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1,
                            input int nedge, input int gap,
                            output logic [7:0] rx, output logic bz);
        logic [15:0] w;
        w = {b0, b1};
        rx = 8'h00;
        bz = 1'b0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nedge; i++) begin
            spi_mosi = (i < 16) ? w[15 - i] : 1'b0;
            repeat (HP) @(negedge clk);
            if (i == 4) bz = busy;
            if (i >= 8 && i < 16) rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HP) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         input int gap);
        int s_ce, s_lr, s_err, s_miso;
        logic [7:0] rx;
        logic bz;
        logic [3:0] a;
        a = b0[3:0];
        s_ce = n_ce; s_lr = n_lr; s_err = n_err; s_miso = n_miso;
        spi_xfer(b0, b1, 16, gap, rx, bz);
        chk("busy_in_frame", 32'(bz), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("no_frame_err", 32'(n_err - s_err), 32'd0);
        if (b0[7]) begin
            chk("rd_strobes", 32'(n_ce - s_ce), 32'd1);
            chk("rd_no_write", 32'(n_lr - s_lr), 32'd0);
            chk("rd_addr", 32'(last_raddr), 32'(a));
            chk("rd_data", 32'(rx), 32'(exp_mem[a]));
        end else begin
            chk("wr_strobes", 32'(n_lr - s_lr), 32'd1);
            chk("wr_no_read", 32'(n_ce - s_ce), 32'd0);
            chk("wr_addr", 32'(last_waddr), 32'(a));
            chk("wr_data", 32'(last_wdata), 32'(b1));
            chk("wr_miso_low", 32'(n_miso - s_miso), 32'd0);
            exp_mem[a] = b1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ce_n"}, 32'(mem_ce_n), 32'd1);
        chk({tag, "_lr_n"}, 32'(mem_lr_n), 32'd1);
        chk({tag, "_miso"}, 32'(spi_miso), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_ce, s_lr, s_err, s_miso;
        logic [7:0] rx;
        logic bz;
        logic [7:0] c, d;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        repeat (4) @(negedge clk);
        chk_reset_outs("rst");
        ram_clr = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_reset_outs("post_rst");

        frame(8'h05, 8'hA5, 10);
        frame(8'h0A, 8'h3C, 10);
        frame(8'h8A, 8'h00, 10);

        s_lr = n_lr; s_err = n_err;
        spi_xfer(8'h03, 8'hFF, 12, 10, rx, bz);
        chk("abort_no_write", 32'(n_lr - s_lr), 32'd0);
        chk("abort_err_pulse", 32'(n_err - s_err), 32'd1);
        frame(8'h03, 8'h11, 10);
        frame(8'h83, 8'h00, 10);

        s_lr = n_lr; s_ce = n_ce; s_err = n_err; s_miso = n_miso;
        spi_xfer(8'h0F, 8'h5A, 24, 10, rx, bz);
        chk("ovr_one_write", 32'(n_lr - s_lr), 32'd1);
        chk("ovr_no_read", 32'(n_ce - s_ce), 32'd0);
        chk("ovr_addr", 32'(last_waddr), 32'hF);
        chk("ovr_data", 32'(last_wdata), 32'h5A);
        chk("ovr_miso_low", 32'(n_miso - s_miso), 32'd0);
        chk("ovr_no_err", 32'(n_err - s_err), 32'd0);
        exp_mem[15] = 8'h5A;
        frame(8'h8F, 8'h00, 10);

        frame(8'h02, 8'h77, 6);
        frame(8'h82, 8'h00, 10);

        @(negedge clk);
        spi_cs_n = 1'b0;
        sclk_edges(10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outs("mid_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s_ce = n_ce; s_lr = n_lr; s_err = n_err;
        sclk_edges(8);
        repeat (HP) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_read", 32'(n_ce - s_ce), 32'd0);
        chk("mid_rst_no_write", 32'(n_lr - s_lr), 32'd0);
        chk("mid_rst_no_err", 32'(n_err - s_err), 32'd0);
        frame(8'h0C, 8'hC3, 10);
        frame(8'h8C, 8'h00, 10);

        for (int k = 0; k < 24; k++) begin
            c = 8'($urandom);
            d = 8'($urandom);
            frame(c, d, 6 + int'($urandom_range(0, 6)));
        end

        chk("never_both_low", 32'(n_both), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_spi_bridge.md
# mem_spi_bridge

SPI-slave command front-end that sits directly upstream of the 16-byte DFF RAM. It receives two-byte SPI frames from an external host, drives the RAM's address, chip-enable, load/read and write-data inputs, and returns read data on MISO. It is the only agent that issues RAM accesses.

## Interface

Parameters:
- ADDR_W, 4, RAM address width; command bits [ADDR_W-1:0] carry the address
- DATA_W, 8, RAM word width and SPI data-byte width
- SYNC_STAGES, 2, flops in each SPI input synchronizer (≥2)

Ports:
- clk  in  1  system clock; everything is in this domain
- rst  in  1  reset, asynchronous, active-high
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  SPI data out, MSB first; 0 when not driving read data
- mem_addr  out  ADDR_W  RAM address
- mem_ce_n  out  1  RAM chip enable, active-low; low for one cycle = read strobe
- mem_lr_n  out  1  RAM load/read, active-low; low for one cycle = write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM registered read data
- busy  out  1  high while synchronized spi_cs_n is low
- frame_err  out  1  one-cycle pulse when a frame is aborted early

## Operation

- spi_sclk, spi_cs_n, spi_mosi each pass through SYNC_STAGES flops; edges detected on the synchronized sclk.
- Frame = cs_n low, exactly 16 sclk rising edges, cs_n high. Byte 0 = command: bit7 = 1 read / 0 write; bits 6:ADDR_W ignored; bits ADDR_W-1:0 = address. Byte 1 = write data (write) or don't-care (read).
- MOSI sampled on synchronized sclk rise; MISO updated on synchronized sclk fall.
- States: IDLE, CMD (edges 1-8), RD_REQ, RD_CAP, DATA (edges 9-16), WR, DONE.
- IDLE -> CMD on cs_n fall; bit counter cleared.
- CMD -> RD_REQ on 8th rise if bit7=1; mem_addr loaded, mem_ce_n=0, mem_lr_n=1 for exactly one cycle.
- RD_REQ -> RD_CAP: RAM updates mem_rdata on that edge; next cycle mem_rdata captured into the MISO shift register -> DATA.
- CMD -> DATA on 8th rise if bit7=0; mem_addr loaded.
- MISO: 0 during CMD and writes; read MSB driven on 8th sclk fall, next bits on falls 9-15.
- DATA, write, 16th rise -> WR: mem_wdata loaded, mem_lr_n=0 for exactly one cycle, mem_ce_n stays 1 -> DONE.
- DATA, read, 16th rise -> DONE.
- DONE: further sclk edges ignored; MISO=0; no second access. cs_n rise -> IDLE.
- cs_n rise in CMD/RD_REQ/RD_CAP/DATA: abort, no write issued, frame_err=1 for one cycle, -> IDLE. Completed read strobes are not undone (reads are side-effect free).
- mem_ce_n and mem_lr_n never low in the same cycle; at most one strobe per frame.
- mem_addr and mem_wdata hold last value between frames.

## Timing

- Reset (asynchronous assert, sync deassert handled upstream): state IDLE, mem_addr=0, mem_wdata=0, mem_ce_n=1, mem_lr_n=1, spi_miso=0, busy=0, frame_err=0, synchronizers 0 except cs_n synchronizer =1.
- Reset mid-frame: frame discarded without write; the block waits for cs_n high, then low, before accepting a new frame.
- sclk high and low phases each ≥4 clk; cs_n setup to first sclk rise and hold after 16th fall each ≥4 clk.
- Read path: 8th rise detected at cycle R (after SYNC_STAGES+1 clk from pin); strobe at R+1, capture at R+2, MISO valid by 8th-fall detect (≥R+4).
- Write strobe: cycle after 16th-rise detect. busy follows cs_n with SYNC_STAGES clk delay.

## Test plan

- Reset: assert rst mid-clock -> all outputs at reset values immediately; no strobe until a new cs_n fall.
- Write: frame 0x05, 0xA5 -> single cycle mem_lr_n=0 with mem_addr=5, mem_wdata=0xA5; mem_ce_n stays 1; frame_err=0.
- Read: RAM model holds 0x3C at addr 0xA; frame 0x8A, 0x00 -> one mem_ce_n=0 cycle with mem_addr=0xA, MISO shifts 0,0,1,1,1,1,0,0.
- Abort: cs_n raised after 12 sclk edges of write frame 0x03, 0xFF -> no mem_lr_n pulse, frame_err one-cycle pulse, next frame 0x03, 0x11 writes 0x11 to addr 3.
- Overrun: 24 sclk edges in write frame 0x0F, 0x5A -> exactly one write (addr 0xF, 0x5A), MISO=0 throughout.
- Back-to-back: write 0x02,0x77 then read 0x82 with minimum cs_n gap -> read returns 0x77, busy tracks each frame.
